// File: rtl/hazard_detect_unit.sv
// Hazard detection and forwarding control for a 5-stage RV32I pipeline.
// Branches resolve in ID, so every operand forward targets the ID stage.
// The unit keeps its own shadow copy of the optype and rd of the instructions
// in EX, MEM and WB, so the datapath does not have to feed them back.
module hazard_detect_unit #(
  parameter int         REG_AW    = 5,
  parameter logic [1:0] OPT_ALU   = 2'b01,
  parameter logic [1:0] OPT_LOAD  = 2'b10,
  parameter logic [1:0] OPT_STORE = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs1use,
  input  logic              rs2use,
  input  logic [1:0]        hazard_optype,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              Branch_ID,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush
);

  logic [1:0]        r_opt_ex, r_opt_mem, r_opt_wb;
  logic [REG_AW-1:0] r_rd_ex, r_rd_mem, r_rd_wb;
  logic [REG_AW-1:0] r_rs2_ex, r_rs2_mem;

  logic              w_wr_ex, w_wr_mem;
  logic              w_load_use;
  logic              w_fwd_ls;
  logic [1:0]        w_fwd_a, w_fwd_b;

  // Operand source for one ID read port; an ALU result in EX wins over MEM.
  // A load sitting in EX cannot be forwarded yet; load_use stalls for it.
  function automatic logic [1:0] fwd_sel(input logic              use_rs,
                                         input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && w_wr_ex && (r_opt_ex == OPT_ALU) && (r_rd_ex == rs))
      sel = 2'b01;
    else if (use_rs && w_wr_mem && (r_rd_mem == rs))
      sel = (r_opt_mem == OPT_ALU) ? 2'b10 : 2'b11;
    return sel;
  endfunction

  // Stage writes a real register (x0 is never a hazard source).
  always_comb begin
    w_wr_ex  = ((r_opt_ex  == OPT_ALU) || (r_opt_ex  == OPT_LOAD)) && (r_rd_ex  != '0);
    w_wr_mem = ((r_opt_mem == OPT_ALU) || (r_opt_mem == OPT_LOAD)) && (r_rd_mem != '0);
  end

  // Forward selects, load-use detection and the late store-data forward.
  // A store whose only EX-load dependency is its data (rs2) is not stalled;
  // the data is patched in MEM from the load result sitting in WB.
  always_comb begin
    w_fwd_a    = fwd_sel(rs1use, rs1_ID);
    w_fwd_b    = fwd_sel(rs2use, rs2_ID);
    w_load_use = (r_opt_ex == OPT_LOAD) && (r_rd_ex != '0) &&
                 ((rs1use && (r_rd_ex == rs1_ID)) ||
                  (rs2use && (r_rd_ex == rs2_ID) && (hazard_optype != OPT_STORE)));
    w_fwd_ls   = (r_opt_mem == OPT_STORE) && (r_opt_wb == OPT_LOAD) &&
                 (r_rd_wb != '0) && (r_rd_wb == r_rs2_mem);
  end

  // Output drive; reset forces a free-running, non-forwarding pipeline.
  // A stall outranks a branch flush: the branch re-evaluates next cycle.
  always_comb begin
    forward_ctrl_A  = w_fwd_a;
    forward_ctrl_B  = w_fwd_b;
    forward_ctrl_ls = w_fwd_ls;
    PC_EN_IF        = ~w_load_use;
    reg_FD_EN       = ~w_load_use;
    reg_DE_flush    = w_load_use;
    reg_FD_flush    = Branch_ID & ~w_load_use;
    if (rst) begin
      forward_ctrl_A  = 2'b00;
      forward_ctrl_B  = 2'b00;
      forward_ctrl_ls = 1'b0;
      PC_EN_IF        = 1'b1;
      reg_FD_EN       = 1'b1;
      reg_DE_flush    = 1'b0;
      reg_FD_flush    = 1'b0;
    end
  end

  // Shadow pipeline: ID enters EX (as a bubble when flushed), then shifts on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opt_ex  <= 2'b00;
      r_opt_mem <= 2'b00;
      r_opt_wb  <= 2'b00;
      r_rd_ex   <= '0;
      r_rd_mem  <= '0;
      r_rd_wb   <= '0;
      r_rs2_ex  <= '0;
      r_rs2_mem <= '0;
    end else begin
      r_opt_ex  <= reg_DE_flush ? 2'b00 : hazard_optype;
      r_rd_ex   <= rd_ID;
      r_rs2_ex  <= rs2_ID;
      r_opt_mem <= r_opt_ex;
      r_rd_mem  <= r_rd_ex;
      r_rs2_mem <= r_rs2_ex;
      r_opt_wb  <= r_opt_mem;
      r_rd_wb   <= r_rd_mem;
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed instruction stream, an in-bench
// model of the in-flight instructions, and literal expectations on key cycles.
module tb_hazard_detect_unit;

  localparam logic [1:0] NOP = 2'b00, ALU = 2'b01, LD = 2'b10, ST = 2'b11;

  logic       clk, rst, rs1use, rs2use, Branch_ID;
  logic [1:0] hazard_optype;
  logic [4:0] rd_ID, rs1_ID, rs2_ID;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;

  hazard_detect_unit dut (
    .clk(clk), .rst(rst), .rs1use(rs1use), .rs2use(rs2use),
    .hazard_optype(hazard_optype), .rd_ID(rd_ID), .rs1_ID(rs1_ID),
    .rs2_ID(rs2_ID), .Branch_ID(Branch_ID),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .PC_EN_IF(PC_EN_IF),
    .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_flush(reg_DE_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst, u1, u2;
    logic [1:0] opt;
    logic [4:0] rd, r1, r2;
    bit         br, lit;
    logic [1:0] ea, eb;
    bit         els, est, efl;
  } vec_t;

  vec_t vecs[$];
  int   n_err = 0;
  int   n_chk = 0;

  // In-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
  logic [1:0] p_opt[3];
  logic [4:0] p_rd[3];
  logic [4:0] p_rs2[3];

  logic [1:0] m_a, m_b;
  logic       m_ls, m_lu, m_fl;

  task automatic add_v(bit r, bit u1, bit u2, logic [1:0] opt, int rd, int r1,
                       int r2, bit br, bit lit, logic [1:0] ea, logic [1:0] eb,
                       bit els, bit est, bit efl);
    vec_t v;
    v.rst = r; v.u1 = u1; v.u2 = u2; v.opt = opt;
    v.rd = 5'(rd); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.br = br; v.lit = lit; v.ea = ea; v.eb = eb;
    v.els = els; v.est = est; v.efl = efl;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, int idx, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", nm, idx, act, exp);
    end
  endtask

  // Where does the ID stage get register rs from?  The youngest older
  // instruction that writes it decides; a load still in EX has no data yet.
  function automatic logic [1:0] m_fwd(bit use_rs, logic [4:0] rs);
    if (!use_rs || rs == 5'd0) return 2'b00;
    if (p_opt[0] == ALU && p_rd[0] == rs) return 2'b01;
    if (p_opt[1] == ALU && p_rd[1] == rs) return 2'b10;
    if (p_opt[1] == LD  && p_rd[1] == rs) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit dep1, dep2;
    dep1 = rs1use && rs1_ID == p_rd[0];
    dep2 = rs2use && rs2_ID == p_rd[0] && hazard_optype != ST;
    m_lu = !rst && p_opt[0] == LD && p_rd[0] != 5'd0 && (dep1 || dep2);
    m_a  = rst ? 2'b00 : m_fwd(rs1use, rs1_ID);
    m_b  = rst ? 2'b00 : m_fwd(rs2use, rs2_ID);
    m_ls = !rst && p_opt[1] == ST && p_opt[2] == LD && p_rd[2] != 5'd0 &&
           p_rd[2] == p_rs2[1];
    m_fl = !rst && Branch_ID && !m_lu;
  endtask

  task automatic model_step();
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        p_opt[k] = NOP; p_rd[k] = 5'd0; p_rs2[k] = 5'd0;
      end
    end else begin
      for (int k = 2; k > 0; k--) begin
        p_opt[k] = p_opt[k-1]; p_rd[k] = p_rd[k-1]; p_rs2[k] = p_rs2[k-1];
      end
      p_opt[0] = m_lu ? NOP : hazard_optype;
      p_rd[0]  = rd_ID;
      p_rs2[0] = rs2_ID;
    end
  endtask

  initial begin
    //     rst u1 u2 opt  rd r1 r2 br lit ea eb ls st fl
    add_v(1, 1, 1, LD,   3, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    add_v(1, 1, 1, LD,   3, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    add_v(0, 1, 1, NOP,  0, 3, 3, 0, 1, 0, 0, 0, 0, 0);
    add_v(0, 1, 1, ALU,  5, 1, 2, 0, 0, 0, 0, 0, 0, 0); // add x5
    add_v(0, 1, 1, NOP,  0, 5, 6, 1, 1, 1, 0, 0, 0, 1); // beq x5,x6
    add_v(0, 0, 0, NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(0, 1, 0, LD,   7, 2, 0, 0, 0, 0, 0, 0, 0, 0); // lw x7
    add_v(0, 1, 1, ALU,  8, 7, 7, 0, 1, 0, 0, 0, 1, 0); // add x8,x7,x7 stall
    add_v(0, 1, 1, ALU,  8, 7, 7, 0, 1, 3, 3, 0, 0, 0); // replay
    add_v(0, 1, 0, ALU,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0); // addi x3
    add_v(0, 1, 0, ALU,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0); // addi x3
    add_v(0, 1, 1, ALU,  9, 3, 0, 0, 1, 1, 0, 0, 0, 0); // sub x9,x3,x0
    add_v(0, 1, 0, ALU,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // addi x0
    add_v(0, 1, 1, ALU,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_v(0, 1, 0, LD,   4, 2, 0, 0, 0, 0, 0, 0, 0, 0); // lw x4
    add_v(0, 1, 1, ST,   0, 2, 4, 0, 1, 0, 0, 0, 0, 0); // sw x4,0(x2)
    add_v(0, 0, 0, NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(0, 0, 0, NOP,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0); // store MEM, load WB
    add_v(0, 1, 0, LD,   1, 2, 0, 0, 0, 0, 0, 0, 0, 0); // lw x1
    add_v(0, 1, 1, NOP,  0, 1, 0, 1, 1, 0, 0, 0, 1, 0); // bne x1,x0 stall
    add_v(0, 1, 1, NOP,  0, 1, 0, 1, 1, 3, 0, 0, 0, 1); // bne replay
    add_v(0, 1, 0, LD,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // lw x0
    add_v(0, 1, 1, ALU,  2, 0, 0, 0, 1, 0, 0, 0, 0, 0); // no stall on x0
    add_v(0, 1, 0, LD,  10, 0, 0, 0, 0, 0, 0, 0, 0, 0); // lw x10
    add_v(0, 1, 0, ALU, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add x11
    add_v(0, 1, 1, ALU, 12,11,10, 0, 1, 1, 3, 0, 0, 0); // EX on A, MEM load on B
    add_v(0, 1, 1, ALU, 13,11,11, 0, 1, 2, 2, 0, 0, 0); // MEM ALU on both
    add_v(0, 0, 0, ALU, 14,12,13, 0, 0, 0, 0, 0, 0, 0); // no reads
    add_v(0, 0, 0, NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_v(1, 1, 1, ALU, 14,14,14, 1, 1, 0, 0, 0, 0, 0); // mid-run reset
    add_v(0, 1, 1, NOP,  0,14,14, 0, 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      p_opt[k] = NOP; p_rd[k] = 5'd0; p_rs2[k] = 5'd0;
    end

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      rst = v.rst;
      if (v.rst) begin
        rs1use        = 1'($urandom_range(0, 1));
        rs2use        = 1'($urandom_range(0, 1));
        hazard_optype = 2'($urandom_range(0, 3));
        rd_ID         = 5'($urandom_range(0, 31));
        rs1_ID        = 5'($urandom_range(0, 31));
        rs2_ID        = 5'($urandom_range(0, 31));
        Branch_ID     = 1'($urandom_range(0, 1));
      end else begin
        rs1use = v.u1; rs2use = v.u2; hazard_optype = v.opt;
        rd_ID = v.rd; rs1_ID = v.r1; rs2_ID = v.r2; Branch_ID = v.br;
      end
      if (v.rst && v.br) Branch_ID = 1'b1;

      @(negedge clk);
      model_eval();
      chk("fwd_A",        i, int'(forward_ctrl_A),  int'(m_a));
      chk("fwd_B",        i, int'(forward_ctrl_B),  int'(m_b));
      chk("fwd_ls",       i, int'(forward_ctrl_ls), int'(m_ls));
      chk("PC_EN_IF",     i, int'(PC_EN_IF),        int'(!m_lu));
      chk("reg_FD_EN",    i, int'(reg_FD_EN),       int'(!m_lu));
      chk("reg_DE_flush", i, int'(reg_DE_flush),    int'(m_lu));
      chk("reg_FD_flush", i, int'(reg_FD_flush),    int'(m_fl));
      if (v.lit) begin
        chk("lit_A",        i, int'(forward_ctrl_A),  int'(v.ea));
        chk("lit_B",        i, int'(forward_ctrl_B),  int'(v.eb));
        chk("lit_ls",       i, int'(forward_ctrl_ls), int'(v.els));
        chk("lit_PC_EN",    i, int'(PC_EN_IF),        int'(!v.est));
        chk("lit_FD_EN",    i, int'(reg_FD_EN),       int'(!v.est));
        chk("lit_DE_flush", i, int'(reg_DE_flush),    int'(v.est));
        chk("lit_FD_flush", i, int'(reg_FD_flush),    int'(v.efl));
        chk("model_A",      i, int'(m_a),             int'(v.ea));
        chk("model_B",      i, int'(m_b),             int'(v.eb));
        chk("model_stall",  i, int'(m_lu),            int'(v.est));
        chk("model_ls",     i, int'(m_ls),            int'(v.els));
      end
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Sits directly downstream of the ID-stage control decoder in the 5-stage RV32I pipeline.
- Consumes the decoder's rs1use, rs2use, hazard_optype and Branch outputs, plus register addresses from ID.
- Tracks the optype and rd of instructions in EX/MEM/WB in internal shadow registers.
- Produces the ID-stage forwarding selects, the store-data forward select, PC/IF-ID enables and the IF-ID/ID-EX flushes. Branches resolve in ID, so operand forwarding targets ID.

Parameters:
- REG_AW, 5, register address width
- OPT_ALU, 2'b01, hazard_optype code: writes rd from ALU
- OPT_LOAD, 2'b10, hazard_optype code: writes rd from memory
- OPT_STORE, 2'b11, hazard_optype code: store, no rd write (2'b00 = no hazard / bubble)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- rs1use  in  1  ID instruction reads rs1
- rs2use  in  1  ID instruction reads rs2
- hazard_optype  in  2  ID instruction optype
- rd_ID  in  REG_AW  dest register of ID instruction
- rs1_ID  in  REG_AW  rs1 address in ID
- rs2_ID  in  REG_AW  rs2 address in ID
- Branch_ID  in  1  taken branch/jump resolved in ID
- forward_ctrl_A  out  2  rs1 source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- forward_ctrl_B  out  2  rs2 source, same encoding
- forward_ctrl_ls  out  1  MEM-stage store data taken from WB load data
- PC_EN_IF  out  1  PC update enable
- reg_FD_EN  out  1  IF/ID register enable
- reg_FD_flush  out  1  IF/ID register flush
- reg_DE_flush  out  1  ID/EX register flush (bubble)

Behaviour:
- State is updated on each rising clk edge: opt_EX/MEM/WB (2b), rd_EX/MEM/WB, rs2_EX/MEM.
- EX update: opt_EX <= reg_DE_flush ? 2'b00 : hazard_optype. rd_EX <= rd_ID. rs2_EX <= rs2_ID.
- Shift: MEM <= EX and WB <= MEM, every cycle, with no stall.
- rst=1 at an edge clears all state to 0. While rst=1, outputs are forced: forwards 00, ls 0, PC_EN_IF=1, reg_FD_EN=1, both flushes 0.
- wr_X = (opt_X==OPT_ALU | opt_X==OPT_LOAD) & rd_X!=0. Register x0 is never a hazard and never forwarded.
- Outputs are combinational from state and ID inputs; there is zero added latency.
- forward_ctrl_A is selected by priority:
  - 01 if rs1use & wr_EX & opt_EX==ALU & rd_EX==rs1_ID.
  - Otherwise 10/11 if rs1use & wr_MEM & rd_MEM==rs1_ID, by opt_MEM ALU/LOAD.
  - Otherwise 00.
  - A MEM match never overrides an EX match. WB is handled by regfile write-first.
- forward_ctrl_B uses the same rules with rs2use/rs2_ID.
- load_use = opt_EX==LOAD & rd_EX!=0 & ((rs1use & rd_EX==rs1_ID) | (rs2use & rd_EX==rs2_ID & hazard_optype!=OPT_STORE)).
- Store exception: a STORE whose only EX-load dependency is via rs2 does not stall.
  - Its data is caught later by forward_ctrl_ls = opt_MEM==STORE & opt_WB==LOAD & rd_WB!=0 & rd_WB==rs2_MEM.
- On load_use, hold for exactly 1 cycle: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1.
  - Next cycle the load is in MEM, so forward 11 applies and the stall drops.
- reg_FD_flush = Branch_ID & ~load_use. A stall takes priority, and the branch is re-evaluated next cycle with correct operands.
- Simultaneous EX and MEM match on both operands is resolved independently per operand.
- Bubbles (opt 00) never match.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> forwards 00, PC_EN_IF=1, reg_FD_EN=1, flushes 0. Next cycle with opt_EX=0 produces no forwards.
- EX forward: `add x5` (opt 01, rd 5) then `beq x5,x6` (rs1use, rs2use) -> forward_ctrl_A=01, B=00, no stall.
- Load-use: `lw x7` then `add x8,x7,x7` -> cycle 1: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1. Cycle 2: A=B=11, no stall.
- Priority and x0:
  - `addi x3`; `addi x3`; `sub x9,x3,x0` -> A=01 (EX wins over MEM).
  - rd=0 in EX with rs1_ID=0 -> A=00.
- Load-store: `lw x4`; `sw x4,0(x2)` -> no stall. Two cycles later, with store in MEM and load in WB, forward_ctrl_ls=1.
- Branch during stall: `lw x1`; `bne x1,x0` with Branch_ID=1 -> cycle 1: reg_FD_flush=0 and stall. Cycle 2: A=11, reg_FD_flush=1.
